// File: rtl/hazard_ctrl.sv
// ID-stage hazard/forwarding controller with mult/div occupancy tracking.
// Optional HAZARD_PERF_EN adds a saturating stall-cycle counter port.
module hazard_ctrl #(
    parameter int FWD_STAGES = 2,
    parameter int REG_W      = 5,
    parameter int DIV_CYCLES = 33,
    parameter int MUL_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        id_valid,
    input  logic [REG_W-1:0]            id_rs,
    input  logic [REG_W-1:0]            id_rt,
    input  logic                        id_use_rs,
    input  logic                        id_use_rt,
    input  logic                        id_md_start,
    input  logic                        id_md_is_div,
    input  logic                        id_reads_hilo,
    input  logic                        flush,
    input  logic [FWD_STAGES-1:0]       stg_valid,
    input  logic [FWD_STAGES-1:0]       stg_wen,
    input  logic [FWD_STAGES-1:0]       stg_ready,
    input  logic [FWD_STAGES*REG_W-1:0] stg_dst,
    output logic [2:0]                  fwd_a,
    output logic [2:0]                  fwd_b,
    output logic                        stall_id,
    output logic                        flush_ex,
    output logic                        md_busy,
    output logic                        md_done,
    output logic [1:0]                  dbg_md_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_md_busy;
    logic             r_md_done;

    logic [2:0] w_fwd_a;
    logic [2:0] w_fwd_b;
    logic       w_haz_a;
    logic       w_haz_b;
    logic       w_md_haz;
    logic       w_stall;
    logic       w_accept;

    // Scan oldest to youngest so the youngest match overwrites; only its ready bit matters.
    always_comb begin
        w_fwd_a = 3'd0;
        w_fwd_b = 3'd0;
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stg_valid[k] && stg_wen[k] && id_use_rs && (id_rs != '0) &&
                (stg_dst[k*REG_W +: REG_W] == id_rs)) begin
                w_fwd_a = 3'(k + 1);
                w_haz_a = !stg_ready[k];
            end
            if (stg_valid[k] && stg_wen[k] && id_use_rt && (id_rt != '0) &&
                (stg_dst[k*REG_W +: REG_W] == id_rt)) begin
                w_fwd_b = 3'(k + 1);
                w_haz_b = !stg_ready[k];
            end
        end
    end

    // ID handshake: id_valid offers an instruction; it leaves ID on any edge where stall_id is low.
    assign w_md_haz = id_valid && (id_md_start || id_reads_hilo) && r_md_busy;
    assign w_stall  = id_valid && !flush && (w_haz_a || w_haz_b || w_md_haz);
    assign w_accept = id_valid && id_md_start && !w_stall && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else if (flush) begin
            r_state   <= MD_IDLE;
            r_cnt     <= '0;
            r_md_busy <= 1'b0;
            r_md_done <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_state   <= MD_BUSY;
                        r_cnt     <= id_md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                        r_md_busy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state   <= MD_DONE;
                        r_md_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= MD_IDLE;
                    r_md_busy <= 1'b0;
                    r_md_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_cnt <= '0;
        end else if (w_stall && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_cnt;
`endif

    assign fwd_a        = w_fwd_a;
    assign fwd_b        = w_fwd_b;
    assign stall_id     = w_stall;
    assign flush_ex     = w_stall;
    assign md_busy      = r_md_busy;
    assign md_done      = r_md_done;
    assign dbg_md_state = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding priority, load-use stalls, mult/div timing, flush and reset.
module tb_hazard_ctrl;

    logic        clk;
    logic        resetn;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_md_start;
    logic        id_md_is_div;
    logic        id_reads_hilo;
    logic        flush;
    logic [1:0]  stg_valid;
    logic [1:0]  stg_wen;
    logic [1:0]  stg_ready;
    logic [9:0]  stg_dst;
    logic [2:0]  fwd_a;
    logic [2:0]  fwd_b;
    logic        stall_id;
    logic        flush_ex;
    logic        md_busy;
    logic        md_done;
    logic [1:0]  dbg_md_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(
        .FWD_STAGES(2),
        .REG_W(5),
        .DIV_CYCLES(33),
        .MUL_CYCLES(2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .id_valid(id_valid),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt),
        .id_md_start(id_md_start),
        .id_md_is_div(id_md_is_div),
        .id_reads_hilo(id_reads_hilo),
        .flush(flush),
        .stg_valid(stg_valid),
        .stg_wen(stg_wen),
        .stg_ready(stg_ready),
        .stg_dst(stg_dst),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .stall_id(stall_id),
        .flush_ex(flush_ex),
        .md_busy(md_busy),
        .md_done(md_done),
        .dbg_md_state(dbg_md_state)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid      = 1'b0;
        id_rs         = 5'd0;
        id_rt         = 5'd0;
        id_use_rs     = 1'b0;
        id_use_rt     = 1'b0;
        id_md_start   = 1'b0;
        id_md_is_div  = 1'b0;
        id_reads_hilo = 1'b0;
        flush         = 1'b0;
        stg_valid     = 2'b00;
        stg_wen       = 2'b00;
        stg_ready     = 2'b00;
        stg_dst       = 10'd0;
    endtask

    // dst1 = MEM destination, dst0 = EX destination
    task automatic set_stages(input logic [1:0] v, input logic [1:0] w, input logic [1:0] r,
                              input logic [4:0] dst1, input logic [4:0] dst0);
        stg_valid = v;
        stg_wen   = w;
        stg_ready = r;
        stg_dst   = {dst1, dst0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_done;
        clear_inputs();
        resetn = 1'b0;
        #2;
        @(negedge clk);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        check("rst_fwd_b", 32'(fwd_b), 32'd0);
        check("rst_stall", 32'(stall_id), 32'd0);
        check("rst_flush_ex", 32'(flush_ex), 32'd0);
        check("rst_md_busy", 32'(md_busy), 32'd0);
        check("rst_md_done", 32'(md_done), 32'd0);
        check("rst_state", 32'(dbg_md_state), 32'd0);
        next_cycle();
        resetn = 1'b1;

        // youngest stage wins forwarding
        id_valid = 1'b1; id_rs = 5'd5; id_use_rs = 1'b1; id_rt = 5'd5; id_use_rt = 1'b0;
        set_stages(2'b11, 2'b11, 2'b11, 5'd5, 5'd5);
        #1;
        check("fwd_both_ex", 32'(fwd_a), 32'd1);
        check("fwd_both_stall", 32'(stall_id), 32'd0);
        check("fwd_rt_unused", 32'(fwd_b), 32'd0);
        set_stages(2'b10, 2'b11, 2'b11, 5'd5, 5'd5);
        #1;
        check("fwd_mem_only", 32'(fwd_a), 32'd2);
        set_stages(2'b11, 2'b01, 2'b11, 5'd5, 5'd5);
        #1;
        check("fwd_mem_no_wen", 32'(fwd_a), 32'd1);
        set_stages(2'b11, 2'b11, 2'b11, 5'd5, 5'd6);
        #1;
        check("fwd_ex_dst_diff", 32'(fwd_a), 32'd2);
        next_cycle();

        // load-use on rt
        id_rs = 5'd3; id_use_rs = 1'b1; id_rt = 5'd8; id_use_rt = 1'b1;
        set_stages(2'b01, 2'b01, 2'b00, 5'd0, 5'd8);
        @(negedge clk);
        check("lu_stall", 32'(stall_id), 32'd1);
        check("lu_flush_ex", 32'(flush_ex), 32'd1);
        check("lu_fwd_b", 32'(fwd_b), 32'd1);
        check("lu_fwd_a", 32'(fwd_a), 32'd0);
        next_cycle();
        set_stages(2'b10, 2'b10, 2'b10, 5'd8, 5'd0);
        @(negedge clk);
        check("lu_mem_fwd_b", 32'(fwd_b), 32'd2);
        check("lu_mem_stall", 32'(stall_id), 32'd0);
        // older ready match does not hide a younger not-ready one
        set_stages(2'b11, 2'b11, 2'b10, 5'd8, 5'd8);
        #1;
        check("lu_young_nr_stall", 32'(stall_id), 32'd1);
        check("lu_young_nr_fwd", 32'(fwd_b), 32'd1);
        // MEM not ready but EX ready and younger: no stall
        set_stages(2'b11, 2'b11, 2'b01, 5'd8, 5'd8);
        #1;
        check("lu_young_rdy_stall", 32'(stall_id), 32'd0);
        // flush and id_valid=0 both suppress the stall
        set_stages(2'b01, 2'b01, 2'b00, 5'd0, 5'd8);
        flush = 1'b1;
        #1;
        check("lu_flush_stall", 32'(stall_id), 32'd0);
        flush = 1'b0; id_valid = 1'b0;
        #1;
        check("lu_novalid_stall", 32'(stall_id), 32'd0);
        id_valid = 1'b1;
        next_cycle();

        // r0 never forwards or stalls
        id_rs = 5'd0; id_use_rs = 1'b1; id_rt = 5'd0; id_use_rt = 1'b1;
        set_stages(2'b01, 2'b01, 2'b00, 5'd0, 5'd0);
        #1;
        check("r0_fwd_a", 32'(fwd_a), 32'd0);
        check("r0_fwd_b", 32'(fwd_b), 32'd0);
        check("r0_stall", 32'(stall_id), 32'd0);
        next_cycle();

        // divide: busy for 34 cycles after accept, done on the 34th, mfhi waits
        clear_inputs();
        id_valid = 1'b1; id_md_start = 1'b1; id_md_is_div = 1'b1;
        #1;
        check("div_issue_stall", 32'(stall_id), 32'd0);
        next_cycle();
        id_md_start = 1'b0; id_md_is_div = 1'b0; id_reads_hilo = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            check($sformatf("div_busy_c%0d", i), 32'(md_busy), (i <= 34) ? 32'd1 : 32'd0);
            check($sformatf("div_done_c%0d", i), 32'(md_done), (i == 34) ? 32'd1 : 32'd0);
            check($sformatf("div_stall_c%0d", i), 32'(stall_id), (i <= 34) ? 32'd1 : 32'd0);
            next_cycle();
        end
        clear_inputs();
        next_cycle();

        // multiply cancelled by a flush one cycle later
        id_valid = 1'b1; id_md_start = 1'b1;
        next_cycle();
        clear_inputs();
        flush = 1'b1;
        @(negedge clk);
        check("mflush_busy_c1", 32'(md_busy), 32'd1);
        check("mflush_stall_c1", 32'(stall_id), 32'd0);
        next_cycle();
        flush = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            saw_done = saw_done | md_done;
            check($sformatf("mflush_busy_%0d", i), 32'(md_busy), 32'd0);
            next_cycle();
        end
        check("mflush_no_done", 32'(saw_done), 32'd0);

        // flush together with md_start: not accepted
        id_valid = 1'b1; id_md_start = 1'b1; flush = 1'b1;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("flush_start_busy", 32'(md_busy), 32'd0);
        next_cycle();

        // back-to-back multiplies: second waits through DONE, issues in first IDLE cycle
        id_valid = 1'b1; id_md_start = 1'b1;
        next_cycle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b_stall_c%0d", i), 32'(stall_id), (i <= 3) ? 32'd1 : 32'd0);
            check($sformatf("b2b_done_c%0d", i), 32'(md_done), (i == 3) ? 32'd1 : 32'd0);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        check("b2b_second_busy", 32'(md_busy), 32'd1);
        check("b2b_second_state", 32'(dbg_md_state), 32'd1);
        next_cycle();

        // reset mid-operation abandons the op
        resetn = 1'b0;
        #1;
        check("rst_mid_busy", 32'(md_busy), 32'd0);
        check("rst_mid_done", 32'(md_done), 32'd0);
        next_cycle();
        resetn = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_done = saw_done | md_done;
            next_cycle();
        end
        check("rst_mid_no_done", 32'(saw_done), 32'd0);

`ifdef HAZARD_PERF_EN
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        id_valid = 1'b1; id_rs = 5'd9; id_use_rs = 1'b1;
        set_stages(2'b01, 2'b01, 2'b00, 5'd0, 5'd9);
        for (int i = 0; i < 10; i++) next_cycle();
        clear_inputs();
        @(negedge clk);
        check("perf_cnt_10", perf_stall_cnt, 32'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the decode (ID) stage. It selects, per source operand, the youngest downstream pipeline stage holding the needed result, and stalls ID on load-use and not-yet-ready hazards. It also tracks the multi-cycle multiply/divide unit, so HI/LO users and new mult/div issues wait. It sits beside the decoder and drives the ID operand muxes, the ID stall, and the EX bubble insert.

## Interface
Parameters:
- FWD_STAGES, 2, number of downstream stages checked for forwarding (stage 0 = EX, 1 = MEM, …); legal 1..7
- REG_W, 5, register index width
- DIV_CYCLES, 33, divider latency in cycles; must be ≥1
- MUL_CYCLES, 2, multiplier latency in cycles; must be ≥1

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs, id_rt  in  REG_W  ID source register indices
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_is_div  in  1  qualifies id_md_start: 1 = divide, 0 = multiply
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- flush  in  1  exception/eret pipeline flush
- stg_valid  in  FWD_STAGES  per-stage valid
- stg_wen  in  FWD_STAGES  per-stage register write enable
- stg_ready  in  FWD_STAGES  per-stage result already available (0 for a load before its data returns)
- stg_dst  in  FWD_STAGES*REG_W  per-stage destination; stage k occupies bits [k*REG_W +: REG_W]
- fwd_a, fwd_b  out  3  operand source: 0 = regfile, k+1 = stage k
- stall_id  out  1  hold PC and ID
- flush_ex  out  1  insert a bubble into EX
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  one-cycle pulse; HI/LO written this cycle

## Operation
- Match for stage k on rs: stg_valid[k] & stg_wen[k] & stg_dst[k]==id_rs & id_rs!=0 & id_use_rs. The same rule applies on rt.
- fwd_a = lowest matching k, plus 1; 0 if there is no match. fwd_b uses the same rule. The youngest stage always wins.
- Data hazard: the lowest matching stage has stg_ready[k]=0. Older ready matches do not cancel it.
- MD FSM states are IDLE, BUSY and DONE; it resets to IDLE with count 0.
  - IDLE → BUSY when id_valid & id_md_start & !stall_id & !flush. count loads (id_md_is_div ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY: count decrements each cycle; when count==0, go to DONE.
  - DONE → IDLE unconditionally; md_done=1 only in DONE.
  - md_busy=1 in BUSY and DONE.
- MD hazard: id_valid & (id_md_start | id_reads_hilo) & md_busy.
- stall_id = id_valid & !flush & (data hazard | MD hazard); flush_ex = stall_id.
- flush overrides everything:
  - FSM goes to IDLE next cycle and count clears.
  - No md_done is generated for the cancelled operation.
  - stall_id = 0 that cycle.
- id_valid=0: stall_id=0. fwd_a and fwd_b are still computed but are don't-care.

## Timing
- fwd_a, fwd_b, stall_id and flush_ex are combinational from inputs and FSM state; they are valid in the same cycle.
- For an op accepted at edge T, BUSY holds for N cycles after T (N = latency). md_done is high in cycle N+1, and the FSM is in IDLE from cycle N+2.
- A back-to-back mult/div stalls through DONE and issues in the first IDLE cycle.
- Reset values: fwd_a=fwd_b=0, stall_id=flush_ex=0, md_busy=md_done=0. Reset mid-operation abandons the op with no md_done.
- Simultaneous flush and md_start: the op is not accepted.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds the output port perf_stall_cnt (32 bits, reset 0).
  - It increments on every cycle with stall_id=1 and saturates at 32'hFFFF_FFFF.
  - flush does not clear it.
- HAZARD_PERF_EN undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- FWD_STAGES=2, EX writes r5 (ready), MEM writes r5 (ready), ID rs=r5 → fwd_a=1, stall_id=0. Make EX invalid → fwd_a=2.
- EX load to r8 (stg_ready[0]=0), ID rt=r8 with use_rt=1 → stall_id=flush_ex=1. Next cycle the load is in MEM and ready → fwd_b=2, stall_id=0.
- ID rs=r0 while EX writes r0 → fwd_a=0, no stall.
- div accepted at T with DIV_CYCLES=33 → md_busy over T+1..T+34, md_done only at T+34. An mfhi in ID during that window stalls and proceeds at T+35.
- mult accepted, flush asserted one cycle later → IDLE next cycle, md_done never pulses, md_busy=0.
- With HAZARD_PERF_EN: 10 stall cycles → perf_stall_cnt=10. Preload near 2^32−1 → holds at 32'hFFFF_FFFF.
